pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage core pipeline (IF, DE, EX, MEM, WB). It drives the per-stage stall and flush controls: `if_stall` and `de_stall` go to the fetch stage, the other stall and flush signals go to the later pipeline registers, and the forwarding selects go to the EX operand muxes. It handles:
- load-use hazards;
- branch squashes;
- multi-cycle EX operations, via a latency counter and FSM;
- data-memory wait states, with a timeout watchdog.

It also keeps stall and flush performance counters.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: EX occupancy in cycles of a multi-cycle op. Legal range is 1..16.
- `MEM_TIMEOUT`, default 8: number of consecutive memory-wait cycles before `mem_error` is set. Legal range is 1..255.

Ports (clk/rst: one clock; reset is synchronous and active-high):
- `clk`  in  1  core clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `de_rs1`, `de_rs2`  in  5 each  source registers of the instruction in DE
- `ex_rs1`, `ex_rs2`  in  5 each  source registers of the instruction in EX
- `ex_rd`  in  5  destination register of the instruction in EX
- `ex_reg_write`  in  1  EX instruction writes `ex_rd`
- `ex_is_load`  in  1  EX instruction is a load
- `ex_multicycle`  in  1  EX instruction needs `MUL_LATENCY` cycles in EX
- `ex_pc_src`  in  1  branch/jump taken, resolved in EX
- `mem_rd`  in  5  destination register of the instruction in MEM
- `mem_reg_write`  in  1  MEM instruction writes `mem_rd`
- `wb_rd`  in  5  destination register of the instruction in WB
- `wb_reg_write`  in  1  WB instruction writes `wb_rd`
- `mem_req_valid`  in  1  MEM stage has a data-memory request outstanding
- `mem_ready`  in  1  data memory completes the request this cycle
- `if_stall`, `de_stall`, `ex_stall`, `mem_stall`  out  1 each  hold the PC / the respective pipeline register
- `de_flush`, `ex_flush`, `mem_flush`, `wb_flush`  out  1 each  load a bubble into the DE / EX / MEM / WB register
- `ex_fwd_a`, `ex_fwd_b`  out  2 each  operand select: 00 = register file, 10 = MEM result, 01 = WB result
- `mem_error`  out  1  sticky memory-timeout flag
- `stall_cycles`  out  32  count of cycles with `if_stall` high
- `flush_count`  out  32  count of branch flushes

## Operation
**Register-zero rule.** A hazard or forward is never raised on register 0.

**Priority of conditions, highest first.**
1. Reset.
2. Memory hold.
3. Multi-cycle hold.
4. Branch.
5. Load-use.
6. Run.

**Reset (`rst` = 1).**
- All stalls are 0.
- `de_flush`, `ex_flush`, `mem_flush` and `wb_flush` are all 1.
- FSM goes to RUN; the multi-cycle counter and the wait counter are cleared.
- `mem_error` = 0; both performance counters = 0.
- Forward selects are 00.

**Memory hold** (`mem_hold` = `mem_req_valid` & ~`mem_ready`).
- `if_stall`, `de_stall`, `ex_stall` and `mem_stall` are 1; `wb_flush` = 1.
- All other flushes are 0; the branch and load-use actions are suppressed.
- The multi-cycle counter and FSM state are frozen.
- The wait counter increments, saturating at 255.
- When the wait counter reaches `MEM_TIMEOUT`, `mem_error` is set on that edge. It stays set until `rst`, and the hold continues regardless.
- The wait counter clears on any cycle without `mem_hold`.

**FSM states: RUN and MC_WAIT.**
- **RUN, `ex_multicycle` = 1, `MUL_LATENCY` > 1:**
  - `if_stall`, `de_stall` and `ex_stall` are 1; `mem_flush` = 1.
  - Counter loads `MUL_LATENCY` − 2; next state is MC_WAIT.
- **MC_WAIT:**
  - Same stalls and `mem_flush` as above.
  - If the counter is 0, next state is RUN; otherwise the counter decrements.
- **`MUL_LATENCY` = 1:** no multi-cycle stall is generated.
- **In the release cycle** (EX advances):
  - `ex_multicycle` is ignored.
  - A pending `ex_pc_src` is acted on then.

**Branch** (`ex_pc_src` = 1 while EX advances).
- `de_flush` = 1 and `ex_flush` = 1; `if_stall` = 0 so the PC loads the target.
- The load-use stall is suppressed.
- `flush_count` increments.

**Load-use** (`ex_is_load` & `ex_reg_write` & `ex_rd` ≠ 0 & (`ex_rd` == `de_rs1` | `ex_rd` == `de_rs2`)).
- `if_stall` = 1, `de_stall` = 1, `ex_flush` = 1.

**Forwarding** (combinational, always evaluated, independent of stalls).
- `ex_fwd_a` = 10 if `mem_reg_write` & `mem_rd` ≠ 0 & `mem_rd` == `ex_rs1`.
- Otherwise `ex_fwd_a` = 01 on the same match against WB.
- Otherwise `ex_fwd_a` = 00.
- `ex_fwd_b` follows the same rule using `ex_rs2`.

**Performance counters.**
- `stall_cycles` increments on every non-reset cycle with `if_stall` = 1.
- Both counters are 32-bit and wrap modulo 2^32.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the registered state, all within the same cycle.
- FSM, counters and `mem_error` update on posedge `clk`.
- **Multi-cycle op entering EX at cycle t:** stalls are asserted in cycles t..t+`MUL_LATENCY`−2; EX advances at t+`MUL_LATENCY`−1.
  - Each `mem_hold` cycle extends this window by one.
- **Load-use:** costs exactly one bubble; the consumer reaches EX two cycles later with forward select 01.
- **Reset mid-MC_WAIT:** the next cycle is RUN with no stalls.

## Test plan
- **Load-use:** EX holds a load of x5, DE has `de_rs1` = 5.
  - Cycle 0: `if_stall` = `de_stall` = `ex_flush` = 1.
  - Cycle 1: no stall.
  - Cycle 2: consumer in EX with `ex_rs1` = 5, `wb_rd` = 5 → `ex_fwd_a` = 01.
  - `stall_cycles` = 1.
- **Branch with load-use present:** `ex_pc_src` = 1 together with a load-use match.
  - `de_flush` = `ex_flush` = 1, `if_stall` = 0, `flush_count` = 1.
- **Multi-cycle op, `MUL_LATENCY` = 4:**
  - Stalls and `mem_flush` held for exactly 3 cycles, then released; `stall_cycles` = 3.
  - Repeat with `mem_hold` for 2 cycles mid-op → 5 stall cycles.
- **Memory wait, `MEM_TIMEOUT` = 4:**
  - `mem_ready` low for 3 cycles → all four stalls plus `wb_flush` for 3 cycles, `mem_error` = 0.
  - Low for 6 cycles → `mem_error` = 1 after the 4th edge and stays 1 until `rst`.
- **Forwarding:**
  - `ex_rs1` = 7 with `mem_rd` = `wb_rd` = 7, both writing → 10.
  - `ex_rs1` = 0 with `mem_rd` = 0, writing → 00.
- **Reset during MC_WAIT:** assert `rst` for 1 cycle.
  - All flushes = 1, stalls = 0, counters = 0.
  - Next cycle is RUN with no stall.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard-information and pipeline-control bundle between the core datapath
// and the pipeline controller.
interface pipeline_ctrl_if;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_is_load;
    logic        ex_multicycle;
    logic        ex_pc_src;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_req_valid;
    logic        mem_ready;

    logic        if_stall;
    logic        de_stall;
    logic        ex_stall;
    logic        mem_stall;
    logic        de_flush;
    logic        ex_flush;
    logic        mem_flush;
    logic        wb_flush;
    logic [1:0]  ex_fwd_a;
    logic [1:0]  ex_fwd_b;
    logic        mem_error;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    // Datapath side: reports pipeline contents, receives controls.
    modport master (
        output de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_is_load,
               ex_multicycle, ex_pc_src, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               mem_req_valid, mem_ready,
        input  if_stall, de_stall, ex_stall, mem_stall, de_flush, ex_flush,
               mem_flush, wb_flush, ex_fwd_a, ex_fwd_b, mem_error, stall_cycles,
               flush_count
    );

    // Controller side.
    modport slave (
        input  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_is_load,
               ex_multicycle, ex_pc_src, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               mem_req_valid, mem_ready,
        output if_stall, de_stall, ex_stall, mem_stall, de_flush, ex_flush,
               mem_flush, wb_flush, ex_fwd_a, ex_fwd_b, mem_error, stall_cycles,
               flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush sequencing, operand
// forwarding, multi-cycle EX tracking, memory-wait watchdog and perf counters.
module pipeline_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int MEM_TIMEOUT = 8
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave pif
);
    typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_e;

    localparam bit         MC_EN   = (MUL_LATENCY > 1);
    localparam logic [3:0] MC_LOAD = MC_EN ? 4'(MUL_LATENCY - 2) : 4'd0;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  mc_cnt_q, mc_cnt_d;
    logic [7:0]  wait_q, wait_d;
    logic        mem_error_q, mem_error_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    logic        mem_hold, mc_start, mc_busy, load_use, branch_take;
    logic        if_stall, de_stall, ex_stall, mem_stall;
    logic        de_flush, ex_flush, mem_flush, wb_flush;
    logic [1:0]  fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && m_rd != 5'd0 && m_rd == rs)
            sel = 2'b10;
        else if (w_we && w_rd != 5'd0 && w_rd == rs)
            sel = 2'b01;
        return sel;
    endfunction

    assign mem_hold = pif.mem_req_valid & ~pif.mem_ready;
    assign mc_start = (state_q == RUN) & pif.ex_multicycle & MC_EN;
    // MC_WAIT with an exhausted counter is the release cycle: EX advances.
    assign mc_busy  = mc_start | ((state_q == MC_WAIT) & (mc_cnt_q != 4'd0));
    assign load_use = pif.ex_is_load & pif.ex_reg_write & (pif.ex_rd != 5'd0) &
                      ((pif.ex_rd == pif.de_rs1) | (pif.ex_rd == pif.de_rs2));

    always_comb begin
        if_stall    = 1'b0;
        de_stall    = 1'b0;
        ex_stall    = 1'b0;
        mem_stall   = 1'b0;
        de_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        wb_flush    = 1'b0;
        branch_take = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst) begin
            de_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
            wb_flush  = 1'b1;
        end else begin
            if (mem_hold) begin
                if_stall  = 1'b1;
                de_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_stall = 1'b1;
                wb_flush  = 1'b1;
            end else if (mc_busy) begin
                if_stall  = 1'b1;
                de_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_flush = 1'b1;
            end else if (pif.ex_pc_src) begin
                de_flush    = 1'b1;
                ex_flush    = 1'b1;
                branch_take = 1'b1;
            end else if (load_use) begin
                if_stall = 1'b1;
                de_stall = 1'b1;
                ex_flush = 1'b1;
            end
            fwd_a = fwd_sel(pif.ex_rs1, pif.mem_rd, pif.mem_reg_write, pif.wb_rd, pif.wb_reg_write);
            fwd_b = fwd_sel(pif.ex_rs2, pif.mem_rd, pif.mem_reg_write, pif.wb_rd, pif.wb_reg_write);
        end
    end

    always_comb begin
        state_d        = state_q;
        mc_cnt_d       = mc_cnt_q;
        wait_d         = 8'd0;
        if (mem_hold)
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        mem_error_d    = mem_error_q | (mem_hold & (wait_d == TIMEOUT));
        stall_cycles_d = stall_cycles_q + {31'd0, if_stall};
        flush_count_d  = flush_count_q + {31'd0, branch_take};
        // A memory hold freezes multi-cycle sequencing entirely.
        if (!mem_hold) begin
            case (state_q)
                RUN: begin
                    if (mc_start) begin
                        mc_cnt_d = MC_LOAD;
                        state_d  = MC_WAIT;
                    end
                end
                MC_WAIT: begin
                    if (mc_cnt_q == 4'd0)
                        state_d = RUN;
                    else
                        mc_cnt_d = mc_cnt_q - 4'd1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            mc_cnt_q       <= 4'd0;
            wait_q         <= 8'd0;
            mem_error_q    <= 1'b0;
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            mc_cnt_q       <= mc_cnt_d;
            wait_q         <= wait_d;
            mem_error_q    <= mem_error_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign pif.if_stall     = if_stall;
    assign pif.de_stall     = de_stall;
    assign pif.ex_stall     = ex_stall;
    assign pif.mem_stall    = mem_stall;
    assign pif.de_flush     = de_flush;
    assign pif.ex_flush     = ex_flush;
    assign pif.mem_flush    = mem_flush;
    assign pif.wb_flush     = wb_flush;
    assign pif.ex_fwd_a     = fwd_a;
    assign pif.ex_fwd_b     = fwd_b;
    assign pif.mem_error    = mem_error_q;
    assign pif.stall_cycles = stall_cycles_q;
    assign pif.flush_count  = flush_count_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; expected responses are queued by
// the driver and checked by an independent negedge monitor.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipeline_ctrl_if pif ();

    pipeline_ctrl #(.MUL_LATENCY(4), .MEM_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd;
        logic       ex_reg_write, ex_is_load, ex_multicycle, ex_pc_src;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic [4:0] wb_rd;
        logic       wb_reg_write, mem_req_valid, mem_ready;
    } stim_t;

    typedef struct packed {
        logic [3:0]  stl;   // if, de, ex, mem
        logic [3:0]  fl;    // de, ex, mem, wb
        logic [1:0]  fa, fb;
        logic        err;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.mem_ready = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input logic [3:0] stl, input logic [3:0] fl,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic err, input int sc, input int fc);
        exp_t e;
        e.stl = stl; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err;
        e.sc = 32'(sc); e.fc = 32'(fc);
        return e;
    endfunction

    task automatic step(input string nm, input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        rst               = s.rst;
        pif.de_rs1        = s.de_rs1;
        pif.de_rs2        = s.de_rs2;
        pif.ex_rs1        = s.ex_rs1;
        pif.ex_rs2        = s.ex_rs2;
        pif.ex_rd         = s.ex_rd;
        pif.ex_reg_write  = s.ex_reg_write;
        pif.ex_is_load    = s.ex_is_load;
        pif.ex_multicycle = s.ex_multicycle;
        pif.ex_pc_src     = s.ex_pc_src;
        pif.mem_rd        = s.mem_rd;
        pif.mem_reg_write = s.mem_reg_write;
        pif.wb_rd         = s.wb_rd;
        pif.wb_reg_write  = s.wb_reg_write;
        pif.mem_req_valid = s.mem_req_valid;
        pif.mem_ready     = s.mem_ready;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one comparison per presented vector.
    initial begin
        exp_t  e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.stl = {pif.if_stall, pif.de_stall, pif.ex_stall, pif.mem_stall};
                a.fl  = {pif.de_flush, pif.ex_flush, pif.mem_flush, pif.wb_flush};
                a.fa  = pif.ex_fwd_a;
                a.fb  = pif.ex_fwd_b;
                a.err = pif.mem_error;
                a.sc  = pif.stall_cycles;
                a.fc  = pif.flush_count;
                n_vec++;
                $display("vec %0d %s stl=%b fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d",
                         n_vec, nm, a.stl, a.fl, a.fa, a.fb, a.err, a.sc, a.fc);
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got stl=%b fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d, need stl=%b fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d",
                             nm, a.stl, a.fl, a.fa, a.fb, a.err, a.sc, a.fc,
                             e.stl, e.fl, e.fa, e.fb, e.err, e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        s = idle();
        rst = 1'b1;
        pif.de_rs1 = '0; pif.de_rs2 = '0; pif.ex_rs1 = '0; pif.ex_rs2 = '0;
        pif.ex_rd = '0; pif.ex_reg_write = 0; pif.ex_is_load = 0;
        pif.ex_multicycle = 0; pif.ex_pc_src = 0; pif.mem_rd = '0;
        pif.mem_reg_write = 0; pif.wb_rd = '0; pif.wb_reg_write = 0;
        pif.mem_req_valid = 0; pif.mem_ready = 1;

        // Reset: flushes high, forwards forced to 00 despite a matching MEM write.
        s = idle(); s.rst = 1; s.ex_rs1 = 7; s.mem_rd = 7; s.mem_reg_write = 1;
        step("reset", s, ex(4'b0000, 4'b1111, 2'b00, 2'b00, 0, 0, 0));

        // Load-use on x5.
        s = idle(); s.ex_is_load = 1; s.ex_reg_write = 1; s.ex_rd = 5; s.de_rs1 = 5;
        step("lu_c0", s, ex(4'b1100, 4'b0100, 2'b00, 2'b00, 0, 0, 0));
        s = idle(); s.de_rs1 = 5; s.mem_rd = 5; s.mem_reg_write = 1;
        step("lu_c1", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 1, 0));
        s = idle(); s.ex_rs1 = 5; s.wb_rd = 5; s.wb_reg_write = 1;
        step("lu_c2", s, ex(4'b0000, 4'b0000, 2'b01, 2'b00, 0, 1, 0));

        // Branch overrides a simultaneous load-use.
        s = idle(); s.ex_pc_src = 1; s.ex_is_load = 1; s.ex_reg_write = 1; s.ex_rd = 6; s.de_rs2 = 6;
        step("br_lu", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 0, 1, 0));
        s = idle();
        step("br_after", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 1, 1));

        // Forwarding priority and register-zero rule.
        s = idle(); s.ex_rs1 = 7; s.ex_rs2 = 9; s.mem_rd = 7; s.mem_reg_write = 1; s.wb_rd = 7; s.wb_reg_write = 1;
        step("fwd_mem", s, ex(4'b0000, 4'b0000, 2'b10, 2'b00, 0, 1, 1));
        s = idle(); s.mem_reg_write = 1; s.wb_reg_write = 1;
        step("fwd_x0", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 1, 1));
        s = idle(); s.ex_rs2 = 12; s.mem_rd = 12; s.wb_rd = 12; s.wb_reg_write = 1;
        step("fwd_wb_b", s, ex(4'b0000, 4'b0000, 2'b00, 2'b01, 0, 1, 1));
        s = idle(); s.ex_is_load = 1; s.ex_reg_write = 1;
        step("lu_x0", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 1, 1));

        // Multi-cycle op, latency 4: three stall cycles, branch taken on release.
        s = idle(); s.ex_multicycle = 1;
        step("mc_t0", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 0, 1, 1));
        step("mc_t1", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 0, 2, 1));
        step("mc_t2", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 0, 3, 1));
        s.ex_pc_src = 1;
        step("mc_rel_br", s, ex(4'b0000, 4'b1100, 2'b00, 2'b00, 0, 4, 1));
        s = idle();
        step("mc_after", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 4, 2));

        // Multi-cycle op extended by two memory-hold cycles.
        s = idle(); s.ex_multicycle = 1;
        step("mch_t0", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 0, 4, 2));
        s.mem_req_valid = 1; s.mem_ready = 0;
        step("mch_h1", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 5, 2));
        step("mch_h2", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 6, 2));
        s.mem_ready = 1;
        step("mch_t1", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 0, 7, 2));
        s = idle(); s.ex_multicycle = 1;
        step("mch_t2", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 0, 8, 2));
        step("mch_rel", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 9, 2));
        s = idle();
        step("mch_after", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 9, 2));

        // Short memory wait (3 cycles) stays below the timeout; branch suppressed.
        s = idle(); s.mem_req_valid = 1; s.mem_ready = 0;
        step("mw3_1", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 9, 2));
        s.ex_pc_src = 1;
        step("mw3_2_br", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 10, 2));
        s.ex_pc_src = 0;
        step("mw3_3", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 11, 2));
        s.mem_ready = 1;
        step("mw3_done", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 12, 2));
        s = idle();
        step("mw3_after", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 12, 2));

        // Long memory wait (6 cycles): error set on the 4th edge, then sticky.
        s = idle(); s.mem_req_valid = 1; s.mem_ready = 0;
        step("mw6_1", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 12, 2));
        step("mw6_2", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 13, 2));
        step("mw6_3", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 14, 2));
        step("mw6_4", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 0, 15, 2));
        step("mw6_5", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 1, 16, 2));
        step("mw6_6", s, ex(4'b1111, 4'b0001, 2'b00, 2'b00, 1, 17, 2));
        s = idle();
        step("mw6_done", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 1, 18, 2));
        step("mw6_sticky", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 1, 18, 2));

        // Reset in the middle of a multi-cycle op.
        s = idle(); s.ex_multicycle = 1;
        step("rmc_t0", s, ex(4'b1110, 4'b0010, 2'b00, 2'b00, 1, 18, 2));
        s.rst = 1;
        step("rmc_rst", s, ex(4'b0000, 4'b1111, 2'b00, 2'b00, 1, 19, 2));
        s = idle();
        step("rmc_run", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0));
        step("rmc_idle", s, ex(4'b0000, 4'b0000, 2'b00, 2'b00, 0, 0, 0));

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
